mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences a single shared synchronous SRAM port between the instruction-fetch (IF) requester and the MEM-stage load/store requester.
- MEM stage has fixed priority because it holds the older instruction. Each access takes a programmable number of wait cycles.
- Generates the freeze signals that hold the PC and the IF/ID, ID/EXE and EXE/MEM pipeline registers while a requester is waiting.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM port.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, extra SRAM cycles per access; legal range 0..15. The internal counter is 4 bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- if_req  input  1  fetch request, held until if_ready
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetched word, valid while if_ready=1
- if_ready  output  1  one-cycle fetch completion pulse
- mem_r_en  input  1  MEM-stage load, from the EXE/MEM register
- mem_w_en  input  1  MEM-stage store, from the EXE/MEM register
- mem_addr  input  ADDR_W  load/store address (the ALU result)
- mem_wdata  input  DATA_W  store value
- mem_rdata  output  DATA_W  load result, valid while mem_ready=1
- mem_ready  output  1  one-cycle load/store completion pulse
- freeze_pipe  output  1  hold EXE/MEM and all earlier stages
- freeze_if  output  1  hold PC and IF/ID
- sram_addr  output  ADDR_W  SRAM address
- sram_wdata  output  DATA_W  SRAM write data
- sram_we  output  1  SRAM write enable
- sram_oe  output  1  SRAM output enable
- sram_rdata  input  DATA_W  SRAM read data
- perf_mem_cnt  output  32  MEM grants counter (optional feature)
- perf_if_cnt  output  32  IF grants counter (optional feature)
- perf_stall_cnt  output  32  freeze_pipe cycle counter (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0; latched address/data 0; owner = NONE.
- States and transitions:
  - IDLE: grant priority is mem_r_en, then mem_w_en, then if_req.
    - On grant, latch address (and wdata for a store), set owner, clear counter, then go to MEM_RD, MEM_WR or IF_RD.
    - No request: stay in IDLE.
  - MEM_RD / IF_RD: sram_oe=1 and sram_addr=latched address.
    - Counter increments each cycle.
    - When counter==WAIT_CYCLES: register sram_rdata into the owner's rdata register and go to DONE.
  - MEM_WR: sram_we=1, with sram_addr and sram_wdata driven from latched values and held stable for all cycles.
    - Exits to DONE when counter==WAIT_CYCLES.
  - DONE: exactly one cycle.
    - The owner's ready output is 1; no new grant is made.
    - Next state is IDLE; owner is cleared.
- Latency: request seen in IDLE at cycle 0 gives ready at cycle WAIT_CYCLES+2. Back-to-back accesses occupy WAIT_CYCLES+3 cycles each.
- Freeze and output rules:
  - freeze_pipe is combinational: (mem_r_en|mem_w_en) & ~mem_ready.
  - freeze_if is combinational: freeze_pipe | (if_req & ~if_ready).
  - rdata registers hold their last value after ready falls.
  - sram_we and sram_oe are 0 in IDLE and DONE.
- mem_r_en and mem_w_en both high: treated as a read. The store is dropped, and the bench flags it as illegal stimulus.
- A requester dropping its request mid-access: the access still completes and ready still pulses. No abort.
- if_req arriving while MEM owns the port waits. A MEM request arriving during an IF access waits for that access's DONE, then wins in IDLE.
- Reset mid-access: the access is abandoned at that edge, with sram_we/sram_oe low from the next cycle. No ready pulse.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - perf_mem_cnt increments on each MEM grant.
  - perf_if_cnt increments on each IF grant.
  - perf_stall_cnt increments on each cycle freeze_pipe=1.
  - All three reset to 0 on rst and wrap modulo 2^32.
- Undefined: the three ports exist but are tied to 0 and no counter logic is built.

Test Plan (WAIT_CYCLES=2 unless stated):
- Load: mem_r_en=1, mem_addr=0x40, SRAM returns 0xDEADBEEF.
  - sram_oe high cycles 1-3; mem_ready=1 and mem_rdata=0xDEADBEEF at cycle 4.
  - freeze_pipe high cycles 0-3, low at cycle 4.
- Store: mem_w_en=1, addr=0x80, wdata=0x12345678.
  - sram_we=1 cycles 1-3 with addr and data stable; mem_ready at cycle 4.
- Contention: if_req and mem_r_en both asserted at cycle 0.
  - MEM granted first with mem_ready at cycle 4.
  - IF granted in IDLE at cycle 5; if_ready at cycle 9.
  - freeze_if high cycles 0-8.
- WAIT_CYCLES=0: IF fetch from 0x0.
  - if_ready at cycle 2; back-to-back fetches complete every 3 cycles.
- Reset asserted during MEM_RD cycle 2.
  - Next cycle: state IDLE, sram_oe=0, no mem_ready; all outputs 0.
- MEM_ARB_PERF_EN defined: 3 loads then 2 fetches.
  - perf_mem_cnt=3, perf_if_cnt=2, perf_stall_cnt=12.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the shared-SRAM arbiter, its two requesters and the SRAM.
// slave  : arbiter side (receives requests, drives readies/freezes/SRAM pins).
// master : environment side (requesters + SRAM model).
// Signals: if_* fetch requester, mem_* load/store requester, sram_* memory
// port, freeze_* pipeline holds, perf_* optional event counters.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              freeze_pipe;
  logic              freeze_if;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_we;
  logic              sram_oe;
  logic [DATA_W-1:0] sram_rdata;

  logic [31:0]       perf_mem_cnt;
  logic [31:0]       perf_if_cnt;
  logic [31:0]       perf_stall_cnt;

  modport slave (
    input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, freeze_pipe, freeze_if,
           sram_addr, sram_wdata, sram_we, sram_oe,
           perf_mem_cnt, perf_if_cnt, perf_stall_cnt
  );

  modport master (
    output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, freeze_pipe, freeze_if,
           sram_addr, sram_wdata, sram_we, sram_oe,
           perf_mem_cnt, perf_if_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and the MEM-stage
// load/store unit. MEM has fixed priority (older instruction). Each access
// spends WAIT_CYCLES+1 cycles on the SRAM, then one DONE cycle with a ready
// pulse to the owner. Also generates the pipeline freeze signals.
// Ports: clk, rst (synchronous, active-high), bus (mem_port_arbiter_if.slave).
// Optional: define MEM_ARB_PERF_EN to build the perf_* grant/stall counters;
// otherwise those outputs are tied to zero.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [2:0] {ST_IDLE, ST_MEM_RD, ST_MEM_WR, ST_IF_RD, ST_DONE} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_MEM, OWN_IF} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic              if_ready_q, if_ready_d;
  logic              sram_we_q, sram_we_d;
  logic              sram_oe_q, sram_oe_d;
  logic              freeze_pipe;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_rdata_q <= '0;
      if_rdata_q  <= '0;
      mem_ready_q <= 1'b0;
      if_ready_q  <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_ready_q <= mem_ready_d;
      if_ready_q  <= if_ready_d;
      sram_we_q   <= sram_we_d;
      sram_oe_q   <= sram_oe_d;
    end
  end

  // Next state; SRAM strobes and readies are computed one cycle ahead so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_rdata_d = mem_rdata_q;
    if_rdata_d  = if_rdata_q;
    mem_ready_d = 1'b0;
    if_ready_d  = 1'b0;
    sram_we_d   = 1'b0;
    sram_oe_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous load and store is taken as a load; the store is lost.
        if (bus.mem_r_en) begin
          state_d   = ST_MEM_RD;
          owner_d   = OWN_MEM;
          cnt_d     = '0;
          addr_d    = bus.mem_addr;
          sram_oe_d = 1'b1;
        end else if (bus.mem_w_en) begin
          state_d   = ST_MEM_WR;
          owner_d   = OWN_MEM;
          cnt_d     = '0;
          addr_d    = bus.mem_addr;
          wdata_d   = bus.mem_wdata;
          sram_we_d = 1'b1;
        end else if (bus.if_req) begin
          state_d   = ST_IF_RD;
          owner_d   = OWN_IF;
          cnt_d     = '0;
          addr_d    = bus.if_addr;
          sram_oe_d = 1'b1;
        end
      end
      ST_MEM_RD, ST_IF_RD: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_DONE;
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = bus.sram_rdata;
            mem_ready_d = 1'b1;
          end else begin
            if_rdata_d = bus.sram_rdata;
            if_ready_d = 1'b1;
          end
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          sram_oe_d = 1'b1;
        end
      end
      ST_MEM_WR: begin
        if (cnt_q == WAIT_LAST) begin
          state_d     = ST_DONE;
          mem_ready_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          sram_we_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Freezes follow the live requests so a stage is held from the cycle it asks.
  assign freeze_pipe     = (bus.mem_r_en | bus.mem_w_en) & ~mem_ready_q;
  assign bus.freeze_pipe = freeze_pipe;
  assign bus.freeze_if   = freeze_pipe | (bus.if_req & ~if_ready_q);

  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_oe    = sram_oe_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_ready  = mem_ready_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_ready   = if_ready_q;

`ifdef MEM_ARB_PERF_EN
  localparam int unsigned PERF_W = 32;

  logic [PERF_W-1:0] perf_mem_q, perf_mem_d;
  logic [PERF_W-1:0] perf_if_q, perf_if_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic              grant_mem, grant_if;

  // Grant events mirror the IDLE priority decision; counters wrap freely.
  always_comb begin
    grant_mem    = (state_q == ST_IDLE) && (bus.mem_r_en || bus.mem_w_en);
    grant_if     = (state_q == ST_IDLE) && !bus.mem_r_en && !bus.mem_w_en && bus.if_req;
    perf_mem_d   = perf_mem_q + PERF_W'(grant_mem);
    perf_if_d    = perf_if_q + PERF_W'(grant_if);
    perf_stall_d = perf_stall_q + PERF_W'(freeze_pipe);
  end

  // Perf counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mem_q   <= '0;
      perf_if_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_mem_q   <= perf_mem_d;
      perf_if_q    <= perf_if_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign bus.perf_mem_cnt   = perf_mem_q;
  assign bus.perf_if_cnt    = perf_if_q;
  assign bus.perf_stall_cnt = perf_stall_q;
`else
  assign bus.perf_mem_cnt   = '0;
  assign bus.perf_if_cnt    = '0;
  assign bus.perf_stall_cnt = '0;
`endif

endmodule
